// File: rtl/host_fifo_bridge.sv
// Host end of the tagged 34-bit FIFO link: buffers host commands into the command FIFO and
// decodes response words into TX/RX shadow registers. Optional macro RSP_WORD_COUNT_EN adds per-tag word counters.
module host_fifo_bridge #(
  parameter int CMD_DEPTH = 2,
  parameter int STATUS_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_tag,
  input  logic [31:0]         cmd_data,
  output logic [33:0]         cmd_fifo_write_data,
  output logic                cmd_fifo_write_inc,
  input  logic                cmd_fifo_write_full,
  input  logic [33:0]         rsp_fifo_read_data,
  output logic                rsp_fifo_read_inc,
  input  logic                rsp_fifo_read_empty,
  output logic                rsp_channel,
  output logic [15:0]         tx_config,
  output logic [STATUS_W-1:0] tx_status,
  output logic [15:0]         rx_config,
  output logic [STATUS_W-1:0] rx_status,
  output logic [31:0]         rx_data,
  output logic                rx_data_valid,
  output logic                shadow_update,
  output logic                protocol_error,
  input  logic                error_clear
`ifdef RSP_WORD_COUNT_EN
  ,
  output logic [15:0]         rsp_count_cfg,
  output logic [15:0]         rsp_count_data,
  output logic [15:0]         rsp_count_status,
  output logic [15:0]         rsp_count_chan
`endif
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} cmd_state_t;

  cmd_state_t     state;
  logic [33:0]    buf_mem [CMD_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_next;
  logic           accept, push;

  assign accept = cmd_valid && cmd_ready;
  assign push   = (state != EMPTY) && !cmd_fifo_write_full;

  always_comb begin
    count_next = count;
    if (accept && !push)
      count_next = count + 1'b1;
    else if (!accept && push)
      count_next = count - 1'b1;
  end

  // Storage carries no reset; occupancy is defined entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (accept)
      buf_mem[wr_ptr] <= {cmd_tag, cmd_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= EMPTY;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      cmd_ready           <= 1'b0;
      cmd_fifo_write_inc  <= 1'b0;
      cmd_fifo_write_data <= '0;
    end else begin
      cmd_fifo_write_inc <= push;
      if (push) begin
        cmd_fifo_write_data <= buf_mem[rd_ptr];
        rd_ptr              <= rd_ptr + 1'b1;
      end
      if (accept)
        wr_ptr <= wr_ptr + 1'b1;
      count     <= count_next;
      cmd_ready <= (count_next < CW'(CMD_DEPTH));
      case (state)
        EMPTY:   if (accept) state <= (count_next == CW'(CMD_DEPTH)) ? FULL : PARTIAL;
        PARTIAL: if (count_next == CW'(CMD_DEPTH)) state <= FULL;
                 else if (count_next == '0) state <= EMPTY;
        FULL:    if (push) state <= PARTIAL;
        default: state <= EMPTY;
      endcase
    end
  end

  logic       pop, bad_data;
  logic [1:0] rsp_tag;

  assign rsp_fifo_read_inc = rst_n && !rsp_fifo_read_empty;
  assign pop               = rsp_fifo_read_inc;
  assign rsp_tag           = rsp_fifo_read_data[33:32];
  assign bad_data          = pop && (rsp_tag == 2'd1) && !rsp_channel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_channel    <= 1'b0;
      tx_config      <= '0;
      tx_status      <= '0;
      rx_config      <= '0;
      rx_status      <= '0;
      rx_data        <= '0;
      rx_data_valid  <= 1'b0;
      shadow_update  <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      shadow_update <= pop && !bad_data;
      rx_data_valid <= pop && (rsp_tag == 2'd1) && rsp_channel;
      if (pop) begin
        case (rsp_tag)
          2'd0: if (rsp_channel) rx_config <= rsp_fifo_read_data[15:0];
                else tx_config <= rsp_fifo_read_data[15:0];
          2'd1: if (rsp_channel) rx_data <= rsp_fifo_read_data[31:0];
          2'd2: if (rsp_channel) rx_status <= rsp_fifo_read_data[STATUS_W-1:0];
                else tx_status <= rsp_fifo_read_data[STATUS_W-1:0];
          default: rsp_channel <= rsp_fifo_read_data[0];
        endcase
      end
      // A new error in the same cycle as a clear must not be lost.
      if (bad_data)
        protocol_error <= 1'b1;
      else if (error_clear)
        protocol_error <= 1'b0;
    end
  end

`ifdef RSP_WORD_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_count_cfg    <= '0;
      rsp_count_data   <= '0;
      rsp_count_status <= '0;
      rsp_count_chan   <= '0;
    end else if (pop) begin
      case (rsp_tag)
        2'd0:    if (rsp_count_cfg    != 16'hFFFF) rsp_count_cfg    <= rsp_count_cfg    + 16'd1;
        2'd1:    if (rsp_count_data   != 16'hFFFF) rsp_count_data   <= rsp_count_data   + 16'd1;
        2'd2:    if (rsp_count_status != 16'hFFFF) rsp_count_status <= rsp_count_status + 16'd1;
        default: if (rsp_count_chan   != 16'hFFFF) rsp_count_chan   <= rsp_count_chan   + 16'd1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_host_fifo_bridge.sv
// Bench for host_fifo_bridge: directed sequences, a response decode table and a random run against a queue model.
module tb_host_fifo_bridge;
  localparam int DEPTH = 2;
  localparam int SW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_tag;
  logic [31:0]   cmd_data;
  logic [33:0]   cmd_fifo_write_data;
  logic          cmd_fifo_write_inc, cmd_fifo_write_full;
  logic [33:0]   rsp_fifo_read_data;
  logic          rsp_fifo_read_inc, rsp_fifo_read_empty;
  logic          rsp_channel;
  logic [15:0]   tx_config, rx_config;
  logic [SW-1:0] tx_status, rx_status;
  logic [31:0]   rx_data;
  logic          rx_data_valid, shadow_update, protocol_error, error_clear;
`ifdef RSP_WORD_COUNT_EN
  logic [15:0]   rsp_count_cfg, rsp_count_data, rsp_count_status, rsp_count_chan;
`endif

  always #5 clk = ~clk;

  host_fifo_bridge #(.CMD_DEPTH(DEPTH), .STATUS_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tag(cmd_tag), .cmd_data(cmd_data),
    .cmd_fifo_write_data(cmd_fifo_write_data), .cmd_fifo_write_inc(cmd_fifo_write_inc),
    .cmd_fifo_write_full(cmd_fifo_write_full),
    .rsp_fifo_read_data(rsp_fifo_read_data), .rsp_fifo_read_inc(rsp_fifo_read_inc),
    .rsp_fifo_read_empty(rsp_fifo_read_empty),
    .rsp_channel(rsp_channel), .tx_config(tx_config), .tx_status(tx_status),
    .rx_config(rx_config), .rx_status(rx_status), .rx_data(rx_data),
    .rx_data_valid(rx_data_valid), .shadow_update(shadow_update),
    .protocol_error(protocol_error), .error_clear(error_clear)
`ifdef RSP_WORD_COUNT_EN
    , .rsp_count_cfg(rsp_count_cfg), .rsp_count_data(rsp_count_data),
    .rsp_count_status(rsp_count_status), .rsp_count_chan(rsp_count_chan)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, " cmd_ready"}, 64'(cmd_ready), 64'd0);
    chk({pfx, " write_inc"}, 64'(cmd_fifo_write_inc), 64'd0);
    chk({pfx, " write_data"}, 64'(cmd_fifo_write_data), 64'd0);
    chk({pfx, " read_inc"}, 64'(rsp_fifo_read_inc), 64'd0);
    chk({pfx, " shadows"}, {rsp_channel, tx_config, tx_status, rx_config, rx_status}, 64'd0);
    chk({pfx, " rx_data"}, 64'(rx_data), 64'd0);
    chk({pfx, " pulses+err"}, 64'({rx_data_valid, shadow_update, protocol_error}), 64'd0);
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_tag = '0; cmd_data = '0; cmd_fifo_write_full = 1'b0;
    rsp_fifo_read_empty = 1'b1; rsp_fifo_read_data = '0; error_clear = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  tag;
    logic [31:0] data;
    logic        clr;
    logic        chan;
    logic [15:0] txc, rxc, txs, rxs;
    logic [31:0] rxd;
    logic        rxv, upd, err;
  } rsp_vec_t;

  rsp_vec_t vecs[9];

  // Reference model state for the random run
  logic [33:0] q[$];
  logic        m_ready, m_winc, m_chan, m_rxv, m_upd, m_err;
  logic [33:0] m_wdata;
  logic [15:0] m_txc, m_rxc, m_txs, m_rxs;
  logic [31:0] m_rxd;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after release", 64'(cmd_ready), 64'd1);

    // Single command: accepted at one edge, pushed at the next.
    cmd_valid = 1'b1; cmd_tag = 2'd0; cmd_data = 32'd87;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t1 no push on accept edge", 64'(cmd_fifo_write_inc), 64'd0);
    @(negedge clk);
    chk("t1 write_inc", 64'(cmd_fifo_write_inc), 64'd1);
    chk("t1 write_data", 64'(cmd_fifo_write_data), 64'h0_0000_0057);
    @(negedge clk);
    chk("t1 single push", 64'(cmd_fifo_write_inc), 64'd0);

    // Backpressure: two commands fit, the third is refused.
    cmd_fifo_write_full = 1'b1;
    cmd_valid = 1'b1; cmd_tag = 2'd1; cmd_data = 32'hAAAA_0001;
    @(negedge clk);
    chk("t2 ready after 1", 64'(cmd_ready), 64'd1);
    cmd_tag = 2'd2; cmd_data = 32'hBBBB_0002;
    @(negedge clk);
    chk("t2 ready after 2", 64'(cmd_ready), 64'd0);
    cmd_tag = 2'd3; cmd_data = 32'hCCCC_0003;
    @(negedge clk);
    chk("t2 ready held 0", 64'(cmd_ready), 64'd0);
    chk("t2 no push while full", 64'(cmd_fifo_write_inc), 64'd0);
    cmd_valid = 1'b0; cmd_fifo_write_full = 1'b0;
    @(negedge clk);
    chk("t2 push1 inc", 64'(cmd_fifo_write_inc), 64'd1);
    chk("t2 push1 data", 64'(cmd_fifo_write_data), {2'd1, 32'hAAAA_0001});
    @(negedge clk);
    chk("t2 push2 inc", 64'(cmd_fifo_write_inc), 64'd1);
    chk("t2 push2 data", 64'(cmd_fifo_write_data), {2'd2, 32'hBBBB_0002});
    @(negedge clk);
    chk("t2 third not taken", 64'(cmd_fifo_write_inc), 64'd0);
    chk("t2 ready restored", 64'(cmd_ready), 64'd1);

    // Response decode table, one word per cycle
    vecs[0] = '{2'd3, 32'd1,          1'b0, 1'b1, 16'd0,  16'h0,    16'd0,    16'd0,  32'd0,      1'b0, 1'b1, 1'b0};
    vecs[1] = '{2'd1, 32'd456791,     1'b0, 1'b1, 16'd0,  16'h0,    16'd0,    16'd0,  32'd456791, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{2'd2, 32'd76,         1'b0, 1'b1, 16'd0,  16'h0,    16'd0,    16'd76, 32'd456791, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{2'd0, 32'h0009_0077,  1'b0, 1'b1, 16'd0,  16'h0077, 16'd0,    16'd76, 32'd456791, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{2'd3, 32'hFFFF_FFFE,  1'b0, 1'b0, 16'd0,  16'h0077, 16'd0,    16'd76, 32'd456791, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{2'd0, 32'd88,         1'b0, 1'b0, 16'd88, 16'h0077, 16'd0,    16'd76, 32'd456791, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{2'd1, 32'd5,          1'b0, 1'b0, 16'd88, 16'h0077, 16'd0,    16'd76, 32'd456791, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{2'd1, 32'd7,          1'b1, 1'b0, 16'd88, 16'h0077, 16'd0,    16'd76, 32'd456791, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{2'd2, 32'hABCD_1234,  1'b0, 1'b0, 16'd88, 16'h0077, 16'h1234, 16'd76, 32'd456791, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      rsp_fifo_read_empty = 1'b0;
      rsp_fifo_read_data  = {vecs[i].tag, vecs[i].data};
      error_clear         = vecs[i].clr;
      #1;
      chk($sformatf("v%0d read_inc", i), 64'(rsp_fifo_read_inc), 64'd1);
      @(negedge clk);
      chk($sformatf("v%0d chan", i), 64'(rsp_channel), 64'(vecs[i].chan));
      chk($sformatf("v%0d cfg", i), {tx_config, rx_config}, {vecs[i].txc, vecs[i].rxc});
      chk($sformatf("v%0d status", i), {tx_status, rx_status}, {vecs[i].txs, vecs[i].rxs});
      chk($sformatf("v%0d rx_data", i), 64'(rx_data), 64'(vecs[i].rxd));
      chk($sformatf("v%0d pulses", i), 64'({rx_data_valid, shadow_update}), 64'({vecs[i].rxv, vecs[i].upd}));
      chk($sformatf("v%0d err", i), 64'(protocol_error), 64'(vecs[i].err));
    end
    rsp_fifo_read_empty = 1'b1; error_clear = 1'b1;
    #1 chk("empty read_inc", 64'(rsp_fifo_read_inc), 64'd0);
    @(negedge clk);
    error_clear = 1'b0;
    chk("err cleared", 64'(protocol_error), 64'd0);
    chk("no update when empty", 64'(shadow_update), 64'd0);
    chk("tx_config kept", 64'(tx_config), 64'd88);

    // Random run against a queue / shadow model, from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    q.delete();
    m_ready = 1'b1; m_winc = 1'b0; m_wdata = '0; m_chan = 1'b0; m_rxv = 1'b0; m_upd = 1'b0;
    m_err = 1'b0; m_txc = '0; m_rxc = '0; m_txs = '0; m_rxs = '0; m_rxd = '0;
    for (int c = 0; c < 600; c++) begin
      logic acc, psh;
      @(negedge clk);
      chk("rnd cmd_ready", 64'(cmd_ready), 64'(m_ready));
      chk("rnd write_inc", 64'(cmd_fifo_write_inc), 64'(m_winc));
      chk("rnd write_data", 64'(cmd_fifo_write_data), 64'(m_wdata));
      chk("rnd chan/cfg", {rsp_channel, tx_config, rx_config}, {m_chan, m_txc, m_rxc});
      chk("rnd status", {tx_status, rx_status}, {m_txs, m_rxs});
      chk("rnd rx_data", 64'(rx_data), 64'(m_rxd));
      chk("rnd flags", 64'({rx_data_valid, shadow_update, protocol_error}), 64'({m_rxv, m_upd, m_err}));
      cmd_valid           = ($urandom_range(0, 1) == 1);
      cmd_tag             = 2'($urandom_range(0, 3));
      cmd_data            = $urandom;
      cmd_fifo_write_full = ($urandom_range(0, 9) < 3);
      rsp_fifo_read_empty = ($urandom_range(0, 9) < 3);
      rsp_fifo_read_data  = {2'($urandom_range(0, 3)), 32'($urandom)};
      error_clear         = ($urandom_range(0, 9) == 0);
      #1 chk("rnd read_inc", 64'(rsp_fifo_read_inc), 64'(!rsp_fifo_read_empty));
      acc = cmd_valid && m_ready;
      psh = (q.size() > 0) && !cmd_fifo_write_full;
      m_winc = psh;
      if (psh) m_wdata = q.pop_front();
      if (acc) q.push_back({cmd_tag, cmd_data});
      m_ready = (q.size() < DEPTH);
      m_rxv = 1'b0; m_upd = 1'b0;
      if (!rsp_fifo_read_empty) begin
        logic [1:0]  t;
        logic [31:0] d;
        t = rsp_fifo_read_data[33:32];
        d = rsp_fifo_read_data[31:0];
        m_upd = 1'b1;
        if (t == 2'd0) begin
          if (m_chan) m_rxc = d[15:0]; else m_txc = d[15:0];
        end else if (t == 2'd1) begin
          if (m_chan) begin m_rxd = d; m_rxv = 1'b1; end
          else begin m_err = 1'b1; m_upd = 1'b0; end
        end else if (t == 2'd2) begin
          if (m_chan) m_rxs = d[SW-1:0]; else m_txs = d[SW-1:0];
        end else begin
          m_chan = d[0];
        end
      end
      if (error_clear && !(!rsp_fifo_read_empty && rsp_fifo_read_data[33:32] == 2'd1 && !m_chan && !m_upd))
        m_err = m_err && !(error_clear && m_upd) && !error_clear;
    end

    // Reset mid-transfer: buffered command and pending response are dropped
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);
    cmd_fifo_write_full = 1'b1;
    cmd_valid = 1'b1; cmd_tag = 2'd2; cmd_data = 32'h1234_5678;
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_fifo_read_empty = 1'b0; rsp_fifo_read_data = {2'd3, 32'd1};
    rst_n = 1'b0;
    #1 chk_all_zero("mid reset");
    @(negedge clk);
    rsp_fifo_read_empty = 1'b1; cmd_fifo_write_full = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post reset no push", 64'(cmd_fifo_write_inc), 64'd0);
    end
    chk("post reset ready", 64'(cmd_ready), 64'd1);
    chk("post reset chan", 64'(rsp_channel), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
